// File: rtl/id_ex_stage_if.sv
// Purpose: ID/EX stage bundle: decode slot, EX/MEM + MEM/WB forwarding sources, EX-side outputs.
// Latency: wires only; timing is defined by the stage that uses it.
// Backpressure: load_use_stall travels back to IF/ID; stall/flush stay plain ports on the stage.
// Ports (slave view): in_* decode fields and control, exmem_*/memwb_* forwarding sources in;
//                     alu_input1/2, alu_control, ex_store_data, ex_* fields, load_use_stall out.
interface id_ex_stage_if;
   // decode slot
   logic        in_valid;
   logic [63:0] in_pc;
   logic [63:0] in_rs1_data;
   logic [63:0] in_rs2_data;
   logic [63:0] in_imm;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic        in_funct7_5;
   logic [1:0]  in_alu_op;
   logic        in_alu_src;
   logic        in_use_pc;
   logic        in_reg_write;
   logic        in_mem_read;
   logic        in_mem_write;
   logic        in_mem_to_reg;
   // forwarding sources
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [63:0] exmem_result;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [63:0] memwb_result;
   // EX side
   logic [63:0] alu_input1;
   logic [63:0] alu_input2;
   logic [3:0]  alu_control;
   logic [63:0] ex_store_data;
   logic        ex_valid;
   logic [63:0] ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_mem_to_reg;
   logic        load_use_stall;

   modport master (
      output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
             in_funct3, in_funct7_5, in_alu_op, in_alu_src, in_use_pc,
             in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg,
             exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
      input  alu_input1, alu_input2, alu_control, ex_store_data, ex_valid, ex_pc, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall
   );

   modport slave (
      input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
             in_funct3, in_funct7_5, in_alu_op, in_alu_src, in_use_pc,
             in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg,
             exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
      output alu_input1, alu_input2, alu_control, ex_store_data, ex_valid, ex_pc, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall
   );
endinterface

// File: rtl/id_ex_stage.sv
// Purpose: ID/EX pipeline register with ALU-code decode, EX operand forwarding and load-use bubbles.
// Latency: decode fields reach EX outputs 1 cycle after capture; forwarding/load_use_stall are combinational.
// Backpressure: stall freezes the stage; load_use_stall holds IF/ID while one bubble is captured.
// Ports: clk, reset (sync, active-high), stall, flush; bus (id_ex_stage_if.slave) carries the decode
//        slot, forwarding sources and all EX-side outputs.
module id_ex_stage (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         flush,
   id_ex_stage_if.slave bus
);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [63:0] rs1_data;
      logic [63:0] rs2_data;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_ctl;
      logic        alu_src;
      logic        use_pc;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
   } ex_regs_t;

   // Reset and bubble share one image: everything zero except an ADD opcode.
   localparam ex_regs_t BUBBLE = '{alu_ctl: ALU_ADD, default: '0};

   function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [2:0] f3,
                                             input logic f7);
      logic [3:0] code;
      code = ALU_ADD;
      case (op)
         2'b00: code = ALU_ADD;
         2'b01: begin
            // Branches compare via subtract (beq/bne) or set-less-than (blt/bge, bltu/bgeu).
            case (f3)
               3'b100, 3'b101: code = ALU_SLT;
               3'b110, 3'b111: code = ALU_SLTU;
               default:        code = ALU_SUB;
            endcase
         end
         default: begin
            case (f3)
               // addi has no subtract form, so funct7[5] only matters for R-type.
               3'b000:  code = (op == 2'b10 && f7) ? ALU_SUB : ALU_ADD;
               3'b001:  code = ALU_SLL;
               3'b010:  code = ALU_SLT;
               3'b011:  code = ALU_SLTU;
               3'b100:  code = ALU_XOR;
               3'b101:  code = f7 ? ALU_SRA : ALU_SRL;
               3'b110:  code = ALU_OR;
               default: code = ALU_AND;
            endcase
         end
      endcase
      return code;
   endfunction

   // EX/MEM is the younger producer, so it wins over MEM/WB.
   function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] reg_val,
                                       input logic em_we, input logic [4:0] em_rd,
                                       input logic [63:0] em_val,
                                       input logic wb_we, input logic [4:0] wb_rd,
                                       input logic [63:0] wb_val);
      logic [63:0] v;
      v = reg_val;
      if (em_we && em_rd != 5'd0 && em_rd == rs) begin
         v = em_val;
      end else if (wb_we && wb_rd != 5'd0 && wb_rd == rs) begin
         v = wb_val;
      end
      return v;
   endfunction

   ex_regs_t    ex_q;
   ex_regs_t    ex_d;
   ex_regs_t    cap;
   logic        load_use;
   logic [63:0] rs1_fwd;
   logic [63:0] rs2_fwd;

   // A stalled stage cannot retire its load, so the hazard is masked while stall is high.
   always_comb begin
      load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & bus.in_valid &
                 ((ex_q.rd == bus.in_rs1) | (ex_q.rd == bus.in_rs2)) & ~stall;
   end

   always_comb begin
      cap            = BUBBLE;
      cap.valid      = bus.in_valid;
      cap.pc         = bus.in_pc;
      cap.rs1_data   = bus.in_rs1_data;
      cap.rs2_data   = bus.in_rs2_data;
      cap.imm        = bus.in_imm;
      cap.rs1        = bus.in_rs1;
      cap.rs2        = bus.in_rs2;
      cap.rd         = bus.in_valid ? bus.in_rd : 5'd0;
      cap.alu_ctl    = alu_decode(bus.in_alu_op, bus.in_funct3, bus.in_funct7_5);
      cap.alu_src    = bus.in_alu_src;
      cap.use_pc     = bus.in_use_pc;
      cap.reg_write  = bus.in_valid & bus.in_reg_write;
      cap.mem_read   = bus.in_valid & bus.in_mem_read;
      cap.mem_write  = bus.in_valid & bus.in_mem_write;
      cap.mem_to_reg = bus.in_valid & bus.in_mem_to_reg;

      ex_d = ex_q;
      if (!stall) begin
         if (flush || load_use) begin
            ex_d = BUBBLE;
         end else begin
            ex_d = cap;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q <= BUBBLE;
      end else begin
         ex_q <= ex_d;
      end
   end

   always_comb begin
      rs1_fwd = fwd(ex_q.rs1, ex_q.rs1_data, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                    bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
      rs2_fwd = fwd(ex_q.rs2, ex_q.rs2_data, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                    bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
   end

   assign bus.alu_input1     = ex_q.use_pc  ? ex_q.pc  : rs1_fwd;
   assign bus.alu_input2     = ex_q.alu_src ? ex_q.imm : rs2_fwd;
   assign bus.alu_control    = ex_q.alu_ctl;
   assign bus.ex_store_data  = rs2_fwd;
   assign bus.ex_valid       = ex_q.valid;
   assign bus.ex_pc          = ex_q.pc;
   assign bus.ex_rd          = ex_q.rd;
   assign bus.ex_reg_write   = ex_q.valid & ex_q.reg_write;
   assign bus.ex_mem_read    = ex_q.valid & ex_q.mem_read;
   assign bus.ex_mem_write   = ex_q.valid & ex_q.mem_write;
   assign bus.ex_mem_to_reg  = ex_q.valid & ex_q.mem_to_reg;
   assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the EX slot.
module tb_id_ex_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, stall, flush;
   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk   (clk),
      .reset (reset),
      .stall (stall),
      .flush (flush),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- behavioural model of the EX slot ----------------
   logic        m_init = 1'b0;   // model meaningful once a reset edge has been seen
   logic        m_known;         // operand/opcode fields defined (valid instr, bubble or reset)
   logic        m_valid, m_src, m_usepc, m_rw, m_mr, m_mw, m_m2r;
   logic [63:0] m_pc, m_d1, m_d2, m_imm;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [3:0]  m_alu;

   // funct3-indexed opcode tables: ALU ops (non-shifted base form) and branch compares
   logic [3:0] alu_tbl [8] = '{4'h2, 4'h4, 4'h7, 4'h8, 4'h3, 4'h5, 4'h1, 4'h0};
   logic [3:0] br_tbl  [8] = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h7, 4'h7, 4'h8, 4'h8};

   function automatic logic [3:0] exp_alu(input logic [1:0] op, input logic [2:0] f3, input logic f7);
      if (op == 2'b00) return 4'h2;
      if (op == 2'b01) return br_tbl[f3];
      if (f3 == 3'd0)  return (op == 2'b10 && f7) ? 4'h6 : 4'h2;
      if (f3 == 3'd5 && f7) return 4'hD;
      return alu_tbl[f3];
   endfunction

   function automatic logic [63:0] m_fwd(input logic [4:0] r, input logic [63:0] v);
      if (r != 0 && bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
      if (r != 0 && bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
      return v;
   endfunction

   function automatic logic exp_lus();
      return m_valid && m_mr && m_rd != 0 && bus.in_valid &&
             (m_rd == bus.in_rs1 || m_rd == bus.in_rs2) && !stall;
   endfunction

   task automatic m_clear();
      m_known = 1'b1; m_valid = 1'b0; m_src = 1'b0; m_usepc = 1'b0;
      m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
      m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_alu = 4'h2;
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_clear();
         m_init = 1'b1;
      end else if (m_init && !stall) begin
         if (flush || exp_lus()) begin
            m_clear();
         end else begin
            m_known = bus.in_valid;
            m_valid = bus.in_valid;
            m_pc    = bus.in_pc;
            m_d1    = bus.in_rs1_data;
            m_d2    = bus.in_rs2_data;
            m_imm   = bus.in_imm;
            m_rs1   = bus.in_rs1;
            m_rs2   = bus.in_rs2;
            m_rd    = bus.in_valid ? bus.in_rd : 5'd0;
            m_alu   = exp_alu(bus.in_alu_op, bus.in_funct3, bus.in_funct7_5);
            m_src   = bus.in_alu_src;
            m_usepc = bus.in_use_pc;
            m_rw    = bus.in_valid && bus.in_reg_write;
            m_mr    = bus.in_valid && bus.in_mem_read;
            m_mw    = bus.in_valid && bus.in_mem_write;
            m_m2r   = bus.in_valid && bus.in_mem_to_reg;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // compare process: away from the active edge, every cycle once the model is meaningful
   always @(negedge clk) begin
      if (m_init) begin
         chk("ex_valid", bus.ex_valid, m_valid);
         chk("ex_rd", bus.ex_rd, m_rd);
         chk("ex_ctl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg},
             {m_rw, m_mr, m_mw, m_m2r});
         chk("load_use_stall", bus.load_use_stall, exp_lus());
         if (m_known) begin
            chk("alu_control", bus.alu_control, m_alu);
            chk("ex_pc", bus.ex_pc, m_pc);
            chk("alu_input1", bus.alu_input1, m_usepc ? m_pc : m_fwd(m_rs1, m_d1));
            chk("alu_input2", bus.alu_input2, m_src ? m_imm : m_fwd(m_rs2, m_d2));
            chk("ex_store_data", bus.ex_store_data, m_fwd(m_rs2, m_d2));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_rs1_data = '0; bus.in_rs2_data = '0;
      bus.in_imm = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
      bus.in_funct3 = '0; bus.in_funct7_5 = 1'b0; bus.in_alu_op = '0;
      bus.in_alu_src = 1'b0; bus.in_use_pc = 1'b0; bus.in_reg_write = 1'b0;
      bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0; bus.in_mem_to_reg = 1'b0;
      bus.exmem_reg_write = 1'b0; bus.exmem_rd = '0; bus.exmem_result = '0;
      bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0; bus.memwb_result = '0;
   endtask

   task automatic set_instr(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                            input logic [63:0] imm, input logic [1:0] op, input logic [2:0] f3,
                            input logic f7, input logic src, input logic rw, input logic mr);
      bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
      bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_imm = imm; bus.in_alu_op = op;
      bus.in_funct3 = f3; bus.in_funct7_5 = f7; bus.in_alu_src = src; bus.in_use_pc = 1'b0;
      bus.in_reg_write = rw; bus.in_mem_read = mr; bus.in_mem_write = 1'b0; bus.in_mem_to_reg = mr;
   endtask

   task automatic rand_inputs();
      reset = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 12);
      flush = ($urandom_range(0, 99) < 10);
      bus.in_valid      = ($urandom_range(0, 99) < 80);
      bus.in_pc         = {$urandom, $urandom};
      bus.in_rs1_data   = {$urandom, $urandom};
      bus.in_rs2_data   = {$urandom, $urandom};
      bus.in_imm        = {$urandom, $urandom};
      bus.in_rs1        = 5'($urandom_range(0, 7));
      bus.in_rs2        = 5'($urandom_range(0, 7));
      bus.in_rd         = 5'($urandom_range(0, 7));
      bus.in_funct3     = 3'($urandom_range(0, 7));
      bus.in_funct7_5   = 1'($urandom_range(0, 1));
      bus.in_alu_op     = 2'($urandom_range(0, 3));
      bus.in_alu_src    = 1'($urandom_range(0, 1));
      bus.in_use_pc     = ($urandom_range(0, 99) < 20);
      bus.in_reg_write  = 1'($urandom_range(0, 1));
      bus.in_mem_read   = ($urandom_range(0, 99) < 35);
      bus.in_mem_write  = 1'($urandom_range(0, 1));
      bus.in_mem_to_reg = 1'($urandom_range(0, 1));
      bus.exmem_reg_write = 1'($urandom_range(0, 1));
      bus.exmem_rd        = 5'($urandom_range(0, 7));
      bus.exmem_result    = {$urandom, $urandom};
      bus.memwb_reg_write = 1'($urandom_range(0, 1));
      bus.memwb_rd        = 5'($urandom_range(0, 7));
      bus.memwb_result    = {$urandom, $urandom};
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      idle();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst ex_valid", bus.ex_valid, 0);
      chk("rst alu_control", bus.alu_control, 4'b0010);
      chk("rst alu_input1", bus.alu_input1, 0);
      chk("rst alu_input2", bus.alu_input2, 0);
      chk("rst ex_store_data", bus.ex_store_data, 0);

      // R-type SUB
      tick();
      set_instr(64'h40, 5'd1, 5'd2, 5'd3, 64'h30, 64'h20, 64'h0, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      @(negedge clk);
      chk("sub alu_control", bus.alu_control, 4'b0110);
      chk("sub alu_input1", bus.alu_input1, 64'h30);
      chk("sub alu_input2", bus.alu_input2, 64'h20);
      chk("sub ex_valid", bus.ex_valid, 1);
      chk("sub ex_rd", bus.ex_rd, 3);

      // I-type SRAI
      tick();
      set_instr(64'h44, 5'd1, 5'd0, 5'd4, 64'h8000, 64'h0, 64'h404, 2'b11, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      @(negedge clk);
      chk("srai alu_control", bus.alu_control, 4'b1101);
      chk("srai alu_input2", bus.alu_input2, 64'h404);

      // forwarding priority, slot held by stall while sources change
      tick();
      set_instr(64'h100, 5'd5, 5'd6, 5'd9, 64'h1111, 64'h2222, 64'h0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      stall = 1'b1;
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 64'hAAAA;
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 64'h5555;
      @(negedge clk);
      chk("fwd exmem wins", bus.alu_input1, 64'hAAAA);
      #1 bus.exmem_rd = 5'd0;
      #1 chk("fwd memwb", bus.alu_input1, 64'h5555);
      #1 bus.memwb_reg_write = 1'b0;
      #1 chk("fwd none", bus.alu_input1, 64'h1111);
      chk("fwd store none", bus.ex_store_data, 64'h2222);
      tick();

      // load-use: ld x7 then add x8, x1, x7
      idle();
      set_instr(64'h200, 5'd2, 5'd0, 5'd7, 64'h1000, 64'h0, 64'h8, 2'b00, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      set_instr(64'h204, 5'd1, 5'd7, 5'd8, 64'h10, 64'h99, 64'h0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("lu stall", bus.load_use_stall, 1);
      tick();
      @(negedge clk);
      chk("lu bubble valid", bus.ex_valid, 0);
      chk("lu bubble reg_write", bus.ex_reg_write, 0);
      chk("lu stall drops", bus.load_use_stall, 0);
      tick();
      idle();
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd7; bus.memwb_result = 64'hBEEF;
      @(negedge clk);
      chk("lu dep valid", bus.ex_valid, 1);
      chk("lu dep operand", bus.alu_input2, 64'hBEEF);

      // stall for 3 cycles (flush overlapping the stall), then flush alone
      tick();
      idle();
      set_instr(64'h300, 5'd1, 5'd2, 5'd3, 64'hF0, 64'h0F, 64'h0, 2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      set_instr(64'h304, 5'd4, 5'd5, 5'd6, 64'h1, 64'h2, 64'h0, 2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         flush = (i > 0);
         tick();
         @(negedge clk);
         chk("stall alu_control", bus.alu_control, 4'b0001);
         chk("stall alu_input1", bus.alu_input1, 64'hF0);
         chk("stall ex_valid", bus.ex_valid, 1);
         chk("stall ex_pc", bus.ex_pc, 64'h300);
      end
      tick();
      stall = 1'b0;
      flush = 1'b1;
      tick();
      idle();
      @(negedge clk);
      chk("flush ex_valid", bus.ex_valid, 0);
      chk("flush alu_control", bus.alu_control, 4'b0010);

      // reset over a held BLTU
      tick();
      set_instr(64'h400, 5'd4, 5'd5, 5'd0, 64'h3, 64'h4, 64'h0, 2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      stall = 1'b1;
      @(negedge clk);
      chk("bltu alu_control", bus.alu_control, 4'b1000);
      #1 reset = 1'b1;
      tick();
      reset = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      chk("rst2 ex_valid", bus.ex_valid, 0);
      chk("rst2 alu_control", bus.alu_control, 4'b0010);
      chk("rst2 alu_input1", bus.alu_input1, 0);
      chk("rst2 ex_pc", bus.ex_pc, 0);

      // randomized traffic, checked by the compare process
      tick();
      repeat (3000) begin
         rand_inputs();
         tick();
      end
      idle();
      tick();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
